// File: rtl/localbus_pkg.sv
// localbus_pkg
//   Shared definitions for the local-bus transmit path:
//   - arb_state_t     : arbiter state encoding (IDLE / SEND / DRAIN)
//   - localbus_clog2  : ceiling log2, used to size the requester index
//   - clamp_unit_num  : maps a requested unit count onto the legal range 1..max
package localbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_t;

    function automatic int unsigned localbus_clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = (n > 0) ? n - 1 : 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // A count of 0 still sends one unit; anything above the sender's
    // capacity is cut to that capacity.
    function automatic logic [7:0] clamp_unit_num(input logic [7:0]  n,
                                                  input int unsigned max_units);
        if (n == 8'd0)
            return 8'd1;
        else if (32'(n) > max_units)
            return 8'(max_units);
        else
            return n;
    endfunction

endpackage

// File: rtl/localbus_rr_pick.sv
// localbus_rr_pick
//   Combinational round-robin picker: finds the first set bit of req at or
//   after index ptr, wrapping around.
//   req   in  REQ_NUM  request vector
//   ptr   in  ID_W     search start index (0..REQ_NUM-1)
//   idx   out ID_W     winning index (0 when nothing is requested)
//   valid out 1        at least one request is set
module localbus_rr_pick #(
    parameter int unsigned REQ_NUM = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [REQ_NUM-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    idx,
    output logic               valid
);

    always_comb begin
        logic [ID_W-1:0] j;
        idx   = '0;
        valid = 1'b0;
        j     = '0;
        for (int unsigned i = 0; i < REQ_NUM; i++) begin
            j = ID_W'((32'(ptr) + i) % REQ_NUM);
            if (!valid && req[j]) begin
                valid = 1'b1;
                idx   = j;
            end
        end
    end

endmodule

// File: rtl/localbus_tx_arbiter.sv
// localbus_tx_arbiter
//   Round-robin scheduler sharing one localbus_sender among REQ_NUM sources.
//   Latches the winner's frame, pulses START to the sender and ACK to the
//   winner; on the sender's almost pulse it can chain the next pending frame
//   with CONTINUE so consecutive frames leave no bus gap.
//   CLK_I, RSTN_I         clock, async active-low reset
//   REQ_I/PDATA_I/UNIT_NUM_I  per-requester level request, frame, unit count
//   ACK_O                 one-cycle grant pulse to the launched requester
//   CHAIN_EN_I            static enable for continue chaining
//   TX_*_O / TX_*_I       sender parallel input and status
//   CUR_ID_O              index of the last launched requester
//   IDLE_O                arbiter is in IDLE
module localbus_tx_arbiter
    import localbus_pkg::*;
#(
    parameter int unsigned REQ_NUM      = 4,
    parameter int unsigned MAX_UNIT_NUM = 4,
    parameter int unsigned UNIT_BIT_NUM = 32,
    parameter int unsigned ID_W         = 2
) (
    input  logic                                        CLK_I,
    input  logic                                        RSTN_I,
    input  logic [REQ_NUM-1:0]                          REQ_I,
    input  logic [REQ_NUM*MAX_UNIT_NUM*UNIT_BIT_NUM-1:0] PDATA_I,
    input  logic [REQ_NUM*8-1:0]                        UNIT_NUM_I,
    output logic [REQ_NUM-1:0]                          ACK_O,
    input  logic                                        CHAIN_EN_I,
    output logic [MAX_UNIT_NUM*UNIT_BIT_NUM-1:0]        TX_PDATA_O,
    output logic [7:0]                                  TX_UNIT_NUM_O,
    output logic                                        TX_START_O,
    output logic                                        TX_CONTINUE_O,
    input  logic                                        TX_BUSY_I,
    input  logic                                        TX_ALMOST_I,
    output logic [ID_W-1:0]                             CUR_ID_O,
    output logic                                        IDLE_O
);

    localparam int unsigned FRAME_W = MAX_UNIT_NUM * UNIT_BIT_NUM;

    arb_state_t          state, state_nxt;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     win_idx;
    logic                win_valid;
    logic                launch, launch_cont;
    logic [FRAME_W-1:0]  sel_pdata;
    logic [7:0]          sel_units;

    localbus_rr_pick #(
        .REQ_NUM (REQ_NUM),
        .ID_W    (ID_W)
    ) u_pick (
        .req   (REQ_I),
        .ptr   (ptr),
        .idx   (win_idx),
        .valid (win_valid)
    );

    // Slice mux written as a compare loop so every select is constant.
    always_comb begin
        sel_pdata = '0;
        sel_units = '0;
        for (int unsigned k = 0; k < REQ_NUM; k++) begin
            if (ID_W'(k) == win_idx) begin
                sel_pdata = PDATA_I[k*FRAME_W +: FRAME_W];
                sel_units = UNIT_NUM_I[k*8 +: 8];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        launch      = 1'b0;
        launch_cont = 1'b0;
        case (state)
            ST_IDLE: begin
                // TX_START_O guard: the sender only reports busy one cycle
                // after it sees START.
                if (win_valid && !TX_BUSY_I && !TX_START_O) begin
                    launch    = 1'b1;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (TX_ALMOST_I) begin
                    if (CHAIN_EN_I && win_valid) begin
                        launch      = 1'b1;
                        launch_cont = 1'b1;
                    end else begin
                        state_nxt = ST_DRAIN;
                    end
                end else if (!TX_BUSY_I && !TX_START_O) begin
                    // Sender went idle without an almost pulse.
                    state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (!TX_BUSY_I)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            ACK_O         <= '0;
            TX_PDATA_O    <= '0;
            TX_UNIT_NUM_O <= '0;
            TX_START_O    <= 1'b0;
            TX_CONTINUE_O <= 1'b0;
            CUR_ID_O      <= '0;
        end else begin
            state         <= state_nxt;
            TX_START_O    <= launch;
            TX_CONTINUE_O <= launch_cont;
            ACK_O         <= '0;
            if (launch) begin
                TX_PDATA_O     <= sel_pdata;
                TX_UNIT_NUM_O  <= clamp_unit_num(sel_units, MAX_UNIT_NUM);
                CUR_ID_O       <= win_idx;
                ACK_O[win_idx] <= 1'b1;
                ptr            <= (win_idx == ID_W'(REQ_NUM - 1)) ? '0 : win_idx + ID_W'(1);
            end
        end
    end

    assign IDLE_O = (state == ST_IDLE);

endmodule

// File: tb/tb_localbus_tx_arbiter.sv
// tb_localbus_tx_arbiter
//   Directed bench for localbus_tx_arbiter with a simple sender model
//   (busy for 4 cycles per unit, almost pulse 3 cycles before the end).
//   Expected launches are queued by the stimulus and checked by a monitor
//   whenever TX_START_O is seen.
module tb_localbus_tx_arbiter;

    localparam int unsigned REQ_NUM      = 4;
    localparam int unsigned MAX_UNIT_NUM = 4;
    localparam int unsigned UNIT_BIT_NUM = 32;
    localparam int unsigned ID_W         = 2;
    localparam int unsigned FW           = MAX_UNIT_NUM * UNIT_BIT_NUM;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [REQ_NUM-1:0]    req;
    logic [REQ_NUM*FW-1:0] pdata;
    logic [REQ_NUM*8-1:0]  unit_num;
    logic                  chain_en;
    logic [REQ_NUM-1:0]    ack;
    logic [FW-1:0]         tx_pdata;
    logic [7:0]            tx_units;
    logic                  tx_start, tx_cont;
    logic                  busy, almost;
    logic [ID_W-1:0]       cur_id;
    logic                  idle;

    localbus_tx_arbiter #(
        .REQ_NUM      (REQ_NUM),
        .MAX_UNIT_NUM (MAX_UNIT_NUM),
        .UNIT_BIT_NUM (UNIT_BIT_NUM),
        .ID_W         (ID_W)
    ) dut (
        .CLK_I         (clk),
        .RSTN_I        (rst_n),
        .REQ_I         (req),
        .PDATA_I       (pdata),
        .UNIT_NUM_I    (unit_num),
        .ACK_O         (ack),
        .CHAIN_EN_I    (chain_en),
        .TX_PDATA_O    (tx_pdata),
        .TX_UNIT_NUM_O (tx_units),
        .TX_START_O    (tx_start),
        .TX_CONTINUE_O (tx_cont),
        .TX_BUSY_I     (busy),
        .TX_ALMOST_I   (almost),
        .CUR_ID_O      (cur_id),
        .IDLE_O        (idle)
    );

    // Sender model: START (re)loads the frame length, almost fires when 3
    // cycles remain, busy drops when it runs out.
    int cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            almost <= 1'b0;
            cnt    <= 0;
        end else begin
            almost <= 1'b0;
            if (tx_start) begin
                busy <= 1'b1;
                cnt  <= int'(tx_units) * 4;
            end else if (busy) begin
                cnt <= cnt - 1;
                if (cnt == 3) almost <= 1'b1;
                if (cnt == 1) busy <= 1'b0;
            end
        end
    end

    typedef struct {
        logic [ID_W-1:0] id;
        logic [7:0]      units;
        logic [FW-1:0]   data;
        logic            cont;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc = 0;
    int   almost_cyc = -100;
    bit   busy_gap = 1'b1;
    bit   last_gap = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic push(input int unsigned id, input int unsigned units,
                        input logic [FW-1:0] data, input bit cont);
        exp_t e;
        e.id    = ID_W'(id);
        e.units = 8'(units);
        e.data  = data;
        e.cont  = cont;
        exp_q.push_back(e);
    endtask

    task automatic set_slot(input int unsigned k, input int unsigned units, input logic [FW-1:0] data);
        pdata[k*FW +: FW]  = data;
        unit_num[k*8 +: 8] = 8'(units);
    endtask

    function automatic logic [FW-1:0] slot_data(input int unsigned k);
        logic [FW-1:0] d;
        for (int unsigned u = 0; u < MAX_UNIT_NUM; u++)
            d[u*UNIT_BIT_NUM +: UNIT_BIT_NUM] = 32'hC000_0000 | (k << 16) | u;
        return d;
    endfunction

    // Monitor / scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && tx_start) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_start: got id %0d expected no launch", cur_id);
            end else begin
                e = exp_q.pop_front();
                chk("ack_onehot", FW'(ack), FW'(1) << e.id);
                chk("cur_id", FW'(cur_id), FW'(e.id));
                chk("unit_num", FW'(tx_units), FW'(e.units));
                chk("pdata", tx_pdata, e.data);
                chk("continue", FW'(tx_cont), FW'(e.cont));
                if (e.cont) begin
                    chk("chain_latency", FW'(cyc - almost_cyc), FW'(1));
                    chk("chain_no_gap", FW'(busy_gap), FW'(0));
                end
            end
            last_gap = busy_gap;
            busy_gap = 1'b0;
        end else if (rst_n && (ack != '0 || tx_cont)) begin
            n_tests++;
            n_fail++;
            $display("FAIL stray_ack_or_continue: got ack %b cont %b expected 0 without start", ack, tx_cont);
        end
        if (!busy && !tx_start) busy_gap = 1'b1;
        if (almost) almost_cyc = cyc;
    end

    task automatic run_until_acks(input int n, input bit auto_drop);
        int got;
        got = 0;
        for (int t = 0; t < 600 && got < n; t++) begin
            @(negedge clk);
            if (ack != '0) begin
                got++;
                if (auto_drop) req = req & ~ack;
            end
        end
        chk("ack_count", FW'(got), FW'(n));
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            if (idle && !busy && !tx_start) ok = 1'b1;
        end
        chk("idle_reached", FW'(ok), FW'(1));
    endtask

    task automatic wait_almost();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            if (almost) ok = 1'b1;
        end
        chk("almost_seen", FW'(ok), FW'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ack"}, FW'(ack), '0);
        chk({tag, "_start"}, FW'(tx_start), '0);
        chk({tag, "_cont"}, FW'(tx_cont), '0);
        chk({tag, "_pdata"}, tx_pdata, '0);
        chk({tag, "_units"}, FW'(tx_units), '0);
        chk({tag, "_cur_id"}, FW'(cur_id), '0);
        chk({tag, "_idle"}, FW'(idle), FW'(1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [FW-1:0] d_single, d_zero, d_nine;

    initial begin
        req      = '0;
        pdata    = '0;
        unit_num = '0;
        chain_en = 1'b0;
        d_single = {64'h0, 32'hA5A5_0002, 32'hA5A5_0001};
        d_zero   = {96'h0, 32'h0000_5A5A};
        d_nine   = {32'h9999_0004, 32'h9999_0003, 32'h9999_0002, 32'h9999_0001};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Single request on index 1: START/ACK one cycle after REQ sampled.
        set_slot(1, 2, d_single);
        push(1, 2, d_single, 1'b0);
        @(negedge clk);
        req = 4'b0010;
        @(posedge clk);
        #1;
        chk("launch_latency_start", FW'(tx_start), FW'(1));
        chk("launch_latency_ack", FW'(ack), FW'(4'b0010));
        @(negedge clk);
        req = '0;
        wait_idle();

        // Round-robin with all four held, no chaining: 0,1,2,3,0.
        do_reset();
        for (int unsigned k = 0; k < REQ_NUM; k++) set_slot(k, k + 1, slot_data(k));
        push(0, 1, slot_data(0), 1'b0);
        push(1, 2, slot_data(1), 1'b0);
        push(2, 3, slot_data(2), 1'b0);
        push(3, 4, slot_data(3), 1'b0);
        push(0, 1, slot_data(0), 1'b0);
        @(negedge clk);
        req = 4'b1111;
        run_until_acks(5, 1'b0);
        req = '0;
        wait_idle();

        // Chaining: pointer is 1, so 2 goes first, then 0 chained.
        chain_en = 1'b1;
        push(2, 3, slot_data(2), 1'b0);
        push(0, 1, slot_data(0), 1'b1);
        @(negedge clk);
        req = 4'b0101;
        run_until_acks(2, 1'b1);
        wait_idle();

        // Unit count clamping.
        chain_en = 1'b0;
        set_slot(1, 0, d_zero);
        push(1, 1, d_zero, 1'b0);
        @(negedge clk);
        req = 4'b0010;
        run_until_acks(1, 1'b1);
        wait_idle();
        set_slot(1, 9, d_nine);
        push(1, 4, d_nine, 1'b0);
        @(negedge clk);
        req = 4'b0010;
        run_until_acks(1, 1'b1);
        wait_idle();

        // Late request during DRAIN: not chained, launched from IDLE.
        chain_en = 1'b1;
        push(0, 1, slot_data(0), 1'b0);
        @(negedge clk);
        req = 4'b0001;
        run_until_acks(1, 1'b1);
        wait_almost();
        @(negedge clk);
        push(3, 4, slot_data(3), 1'b0);
        req = 4'b1000;
        run_until_acks(1, 1'b1);
        @(posedge clk);
        chk("late_req_after_bus_idle", FW'(last_gap), FW'(1));
        wait_idle();

        // Async reset mid-SEND; pointer would be 2 without the reset.
        chain_en = 1'b0;
        push(1, 4, d_nine, 1'b0);
        @(negedge clk);
        req = 4'b0010;
        run_until_acks(1, 1'b1);
        repeat (3) @(negedge clk);
        chk("in_send_before_reset", FW'(idle), FW'(0));
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push(0, 1, slot_data(0), 1'b0);
        push(3, 4, slot_data(3), 1'b0);
        @(negedge clk);
        req = 4'b1001;
        run_until_acks(2, 1'b1);
        wait_idle();

        chk("queue_empty", FW'(exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/localbus_tx_arbiter.md
# localbus_tx_arbiter

Round-robin scheduler that shares one `localbus_sender` among `REQ_NUM` requesters. It latches the winning requester's frame, launches it on the sender, and acknowledges the requester. When the sender's almost pulse arrives and another request is pending, it chains the next frame with the continue flag, so back-to-back frames leave no idle gap on the bus. It sits between the packet sources and the sender's parallel input.

## Interface
- `REQ_NUM`, 4: number of requesters, 2..16.
- `MAX_UNIT_NUM`, 4: max units per frame; must match the sender.
- `UNIT_BIT_NUM`, 32: bits per unit; must match the sender; even and ≥8.
- `ID_W`, 2: width of the requester index, equal to clog2(`REQ_NUM`).
- `CLK_I`  in  1  single clock; all logic on the rising edge.
- `RSTN_I`  in  1  asynchronous, active-low reset.
- `REQ_I`  in  `REQ_NUM`  level request per requester; held until its `ACK_O`.
- `PDATA_I`  in  `REQ_NUM*MAX_UNIT_NUM*UNIT_BIT_NUM`  frame data; requester k occupies slice k; stable while `REQ_I[k]` is high.
- `UNIT_NUM_I`  in  `REQ_NUM*8`  unit count per requester, slice k.
- `ACK_O`  out  `REQ_NUM`  one-cycle pulse; the frame was handed to the sender.
- `CHAIN_EN_I`  in  1  enables continue chaining (static).
- `TX_PDATA_O`  out  `MAX_UNIT_NUM*UNIT_BIT_NUM`  drives the sender's `PDATA_I`.
- `TX_UNIT_NUM_O`  out  8  drives the sender's `VALID_UNIT_NUM_I`.
- `TX_START_O`  out  1  drives the sender's `START_I`; one-cycle pulse.
- `TX_CONTINUE_O`  out  1  drives the sender's `CONTINUE_I`.
- `TX_BUSY_I`  in  1  the sender's `BUSY_O`.
- `TX_ALMOST_I`  in  1  the sender's `ALMOST_PULSE_O`.
- `CUR_ID_O`  out  `ID_W`  index of the requester whose frame was launched last.
- `IDLE_O`  out  1  high in the IDLE state.

## Operation
- **States:** IDLE, SEND, DRAIN.
- **IDLE:**
  - Launch when any `REQ_I` is high, `TX_BUSY_I`=0 and `TX_START_O`=0.
  - The winner is chosen round-robin (see Arbitration).
  - Registered on that edge: `TX_PDATA_O`, `TX_UNIT_NUM_O`, `CUR_ID_O`; `TX_START_O`=1; `TX_CONTINUE_O`=0; `ACK_O[winner]`=1.
  - Next state: SEND.
- **SEND:**
  - Wait for `TX_ALMOST_I`.
  - On almost, if `CHAIN_EN_I`=1 and some `REQ_I` is high: on the next edge launch the winner as in IDLE, but with `TX_CONTINUE_O`=1. Stay in SEND.
  - On almost otherwise: go to DRAIN.
  - If `TX_BUSY_I`=0 with `TX_START_O`=0 before any almost (protocol fault): return to IDLE.
- **DRAIN:** when `TX_BUSY_I`=0, go to IDLE. Requests that arrive during DRAIN wait for IDLE; they are never chained.
- **Unit count:** a `UNIT_NUM_I` of 0 is sent as 1. A count above `MAX_UNIT_NUM` is clamped to `MAX_UNIT_NUM`.
- **Arbitration:**
  - A pointer holds the last granted index + 1, modulo `REQ_NUM`.
  - The winner is the first high `REQ_I` at or after the pointer, wrapping.
  - The pointer updates only on a launch.
- Only one request is acknowledged per launch; there are no simultaneous ACKs.

## Timing
- Reset (async assert, synchronous release): state IDLE, pointer 0, every output 0 except `IDLE_O`=1.
- Reset mid-frame: the arbiter returns to IDLE immediately. No ACK is issued for an un-launched frame.
- **Launch latency:** `TX_START_O` and `ACK_O` rise one cycle after `REQ_I` is sampled high in IDLE with the bus free.
- **Chain latency:** `TX_START_O` with `TX_CONTINUE_O` rises exactly one cycle after `TX_ALMOST_I`. The sender is still in its shift state then, because `UNIT_BIT_NUM`≥8.
- `TX_CONTINUE_O` is high only in the cycle `TX_START_O` is high.
- `TX_PDATA_O` and `TX_UNIT_NUM_O` hold until the next launch.
- A requester may drop `REQ_I` the cycle after its ACK. A request still high after its ACK counts as a new frame.
- A request dropped before being granted is withdrawn without an ACK.

## Structure
- Package `localbus_pkg`: state encoding constants, the clog2 function for `ID_W`, and the unit-count clamp function.
- Sub-module `localbus_rr_pick`: combinational round-robin pick of `REQ_NUM` bits from the pointer. It outputs the winner index and a valid flag. The pointer register stays in the arbiter.
- The slice mux for `PDATA_I`/`UNIT_NUM_I` is inline.

## Test plan
- **Single request:** REQ_NUM=4, `REQ_I`=0010, unit count 2, data 0xA5A5_0001/0xA5A5_0002.
  - `ACK_O`=0010 and `TX_START_O`=1 one cycle later; `TX_CONTINUE_O`=0; `CUR_ID_O`=1.
  - The sender's DQ stream matches the data.
  - The arbiter returns to IDLE after busy falls.
- **Round-robin:** `REQ_I`=1111 held, `CHAIN_EN_I`=0.
  - Grant order is 0,1,2,3,0 (each request re-raised after its ACK).
  - There are ≥4 idle cycles between frames.
- **Chaining:** `CHAIN_EN_I`=1, requesters 0 and 2 pending.
  - The second START, with CONTINUE=1, comes 1 cycle after `TX_ALMOST_I`.
  - DE from the sender stays high continuously across both frames.
- **Count edge cases:** unit count 0 gives `TX_UNIT_NUM_O`=1; unit count 9 with MAX=4 gives 4.
- **Late request:** a request raised during DRAIN is not chained; it is launched from IDLE after `TX_BUSY_I`=0.
- **Async reset mid-SEND:** all outputs are 0 within the reset, `IDLE_O`=1, and the pointer is 0. After release, `REQ_I`=1000 is granted to index 3.
